fp_result_display_sequencer: RTL and testbench

- Sequences a 32-bit floating-point adder result onto the 2-digit hex 7-segment display, one byte (two hex digits) at a time.
- Captures the result through a valid/ready handshake and presents bytes MSB-first (sign/exponent byte first).
- Advances bytes automatically on a dwell timer or manually on a debounced push-button.
- Sits between the FP adder output and the display's 8-bit data input.

---
 rtl/fp_result_display_sequencer.sv | 143 ++++++++++++++
 tb/tb_fp_result_display_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_display_sequencer.sv
// Shows a captured 32-bit FP adder result on a 2-digit hex display, one byte at a time,
// MSB-first. Bytes advance on a dwell timer (auto_mode) or on a debounced push-button.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   result        FP adder result word
//   result_valid  result holds a new word
//   result_ready  combinational, high when a word can be accepted
//   clear         synchronous return to IDLE (word register kept)
//   auto_mode     1 = timed advance, 0 = button advance only
//   next_btn      raw push-button, synchronous to clk
//   data_out      byte driven to the display
//   byte_sel      index of the byte shown (3 = result[31:24] .. 0 = result[7:0])
//   showing       high while in SHOW
module fp_result_display_sequencer #(
  parameter int unsigned DWELL_CYCLES    = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] result,
  input  logic        result_valid,
  output logic        result_ready,
  input  logic        clear,
  input  logic        auto_mode,
  input  logic        next_btn,
  output logic [7:0]  data_out,
  output logic [1:0]  byte_sel,
  output logic        showing
);

  localparam int unsigned DwellW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);
  localparam logic [DbW-1:0]    DbLast    = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {StIdle, StShow} state_e;

  state_e            state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_sel_q, byte_sel_d;
  logic [7:0]        data_out_q, data_out_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [DbW-1:0]    db_cnt_q, db_cnt_d;
  logic              db_level_q, db_level_d;
  logic              pulse_q, pulse_d;
  // Set once the button has been seen released; a button held through reset must be
  // released before it can produce a press.
  logic              armed_q, armed_d;

  logic transfer;
  logic dwell_tc;
  logic advance;

  assign result_ready = ((state_q == StIdle) || (state_q == StShow)) && !clear;
  assign transfer     = result_valid && result_ready;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_sel_d = byte_sel_q;
    dwell_d    = dwell_q;
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    armed_d    = armed_q | ~next_btn;
    dwell_tc   = 1'b0;
    advance    = 1'b0;

    // Debounce: level rises after DEBOUNCE_CYCLES consecutive high samples.
    if (!next_btn) begin
      db_cnt_d   = '0;
      db_level_d = 1'b0;
    end else if (armed_q && !db_level_q) begin
      if (db_cnt_q == DbLast) begin
        db_level_d = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    pulse_d = db_level_d & ~db_level_q;

    // Priority: clear > transfer > advance.
    if (clear) begin
      state_d    = StIdle;
      byte_sel_d = 2'd3;
      dwell_d    = '0;
    end else if (transfer) begin
      state_d    = StShow;
      word_d     = result;
      byte_sel_d = 2'd3;
      dwell_d    = '0;
    end else if (state_q == StShow) begin
      dwell_tc = auto_mode && (dwell_q == DwellLast);
      advance  = pulse_q || dwell_tc;
      if (!auto_mode || advance) begin
        dwell_d = '0;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
      if (advance) begin
        byte_sel_d = byte_sel_q - 2'd1;  // 0 wraps to 3
      end
    end else begin
      dwell_d = '0;
    end

    if (state_d == StShow) begin
      data_out_d = word_d[{byte_sel_d, 3'b000} +: 8];
    end else begin
      data_out_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      word_q     <= '0;
      byte_sel_q <= 2'd3;
      data_out_q <= 8'h00;
      dwell_q    <= '0;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      pulse_q    <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_sel_q <= byte_sel_d;
      data_out_q <= data_out_d;
      dwell_q    <= dwell_d;
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      pulse_q    <= pulse_d;
      armed_q    <= armed_d;
    end
  end

  assign data_out = data_out_q;
  assign byte_sel = byte_sel_q;
  assign showing  = (state_q == StShow);

endmodule

// File: tb/tb_fp_result_display_sequencer.sv
module tb_fp_result_display_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        clear;
  logic        auto_mode;
  logic        next_btn;
  logic [7:0]  data_out;
  logic [1:0]  byte_sel;
  logic        showing;

  int n_checks;
  int n_errors;

  fp_result_display_sequencer #(
    .DWELL_CYCLES   (4),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .clear       (clear),
    .auto_mode   (auto_mode),
    .next_btn    (next_btn),
    .data_out    (data_out),
    .byte_sel    (byte_sel),
    .showing     (showing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int idx);
    return w[idx*8 +: 8];
  endfunction

  localparam logic [31:0] WordA = 32'h40490FDB;
  localparam logic [31:0] WordB = 32'hC2280000;

  initial begin
    int exp_idx;
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    result       = 32'h0;
    result_valid = 1'b0;
    clear        = 1'b0;
    auto_mode    = 1'b0;
    next_btn     = 1'b0;
    step();
    step();
    check_eq("rst_data", 32'(data_out), 32'h00);
    check_eq("rst_sel", 32'(byte_sel), 32'd3);
    check_eq("rst_show", 32'(showing), 32'd0);
    check_eq("rst_ready", 32'(result_ready), 32'd1);
    reset = 1'b0;
    step();

    // Handshake with auto rotation starting at the transfer edge.
    result       = WordA;
    result_valid = 1'b1;
    auto_mode    = 1'b1;
    #1;
    check_eq("hs_ready", 32'(result_ready), 32'd1);
    step();
    result_valid = 1'b0;
    check_eq("hs_show", 32'(showing), 32'd1);
    for (int i = 0; i < 20; i++) begin
      exp_idx = 3 - ((i / 4) % 4);
      check_eq($sformatf("auto_sel%0d", i), 32'(byte_sel), 32'(exp_idx));
      check_eq($sformatf("auto_data%0d", i), 32'(data_out), 32'(byte_of(WordA, exp_idx)));
      step();
    end

    // Manual mode, restart word at byte 3.
    auto_mode    = 1'b0;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    check_eq("man_start", 32'(data_out), 32'h40);

    // Two-cycle glitch: no advance.
    next_btn = 1'b1;
    step();
    step();
    next_btn = 1'b0;
    step();
    step();
    step();
    check_eq("glitch_sel", 32'(byte_sel), 32'd3);
    check_eq("glitch_data", 32'(data_out), 32'h40);

    // Hold 10 cycles: exactly one advance on the 4th edge.
    next_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check_eq($sformatf("hold_data%0d", k), 32'(data_out), (k < 4) ? 32'h40 : 32'h49);
    end
    next_btn = 1'b0;
    step();
    step();

    // Dwell terminal count coinciding with press pulse on edge 4.
    auto_mode = 1'b1;
    next_btn  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_idx = (k < 4) ? 2 : ((k < 8) ? 1 : 0);
      check_eq($sformatf("simul_sel%0d", k), 32'(byte_sel), 32'(exp_idx));
    end
    check_eq("simul_data", 32'(data_out), 32'hDB);
    next_btn = 1'b0;
    for (int k = 0; k < 12; k++) step();
    check_eq("pre_restart_sel", 32'(byte_sel), 32'd1);
    check_eq("pre_restart_data", 32'(data_out), 32'h0F);

    // Restart in SHOW with a new word, full dwell follows.
    result       = WordB;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    check_eq("restart_sel", 32'(byte_sel), 32'd3);
    check_eq("restart_data", 32'(data_out), 32'hC2);
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq($sformatf("restart_dwell%0d", k), 32'(data_out), (k < 4) ? 32'hC2 : 32'h28);
    end
    auto_mode = 1'b0;

    // Clear and valid together: clear wins.
    result       = 32'h12345678;
    result_valid = 1'b1;
    clear        = 1'b1;
    #1;
    check_eq("clr_ready", 32'(result_ready), 32'd0);
    step();
    result_valid = 1'b0;
    clear        = 1'b0;
    check_eq("clr_show", 32'(showing), 32'd0);
    check_eq("clr_data", 32'(data_out), 32'h00);
    check_eq("clr_sel", 32'(byte_sel), 32'd3);
    step();
    check_eq("clr_stay_idle", 32'(showing), 32'd0);

    // Reset mid-operation with the button held.
    result       = WordA;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    check_eq("pre_rst_data", 32'(data_out), 32'h40);
    next_btn = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_rst_data", 32'(data_out), 32'h00);
    check_eq("mid_rst_sel", 32'(byte_sel), 32'd3);
    check_eq("mid_rst_show", 32'(showing), 32'd0);
    check_eq("mid_rst_ready", 32'(result_ready), 32'd1);
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    check_eq("post_rst_data", 32'(data_out), 32'h40);
    for (int k = 0; k < 8; k++) step();
    check_eq("held_no_pulse", 32'(byte_sel), 32'd3);
    next_btn = 1'b0;
    step();
    next_btn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq($sformatf("repress_sel%0d", k), 32'(byte_sel), (k < 4) ? 32'd3 : 32'd2);
    end
    check_eq("repress_data", 32'(data_out), 32'h49);
    next_btn = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
